hazard_req: RTL and testbench
=============================

Name: hazard_req

Overview:
- Sits in the EX stage and produces the hold request that the hold controller consumes.
- Detects three conditions:
  - load-use hazards between the ID and EX instructions;
  - taken branches/jumps resolved in EX;
  - multi-cycle mul/div operations occupying EX.
- Drives hold type, jump flag and jump address toward the hold controller.
- Keeps a wait-state FSM for mul/div, a timeout watchdog, and saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of performance counters o_stall_cnt and o_flush_cnt.
- MD_TIMEOUT, 64, max cycles in MD_BUSY before o_md_err is raised.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  reset, synchronous, active-high (1 = reset).
- i_id_rs1_addr  input  5  rs1 index of the instruction in ID.
- i_id_rs1_re  input  1  ID instruction reads rs1.
- i_id_rs2_addr  input  5  rs2 index of the instruction in ID.
- i_id_rs2_re  input  1  ID instruction reads rs2.
- i_ex_valid  input  1  EX holds a real instruction (0 = bubble).
- i_ex_mem_re  input  1  EX instruction is a load.
- i_ex_rd_addr  input  5  EX destination register.
- i_ex_rd_we  input  1  EX instruction writes rd.
- i_ex_jump  input  1  EX branch/jump resolved taken.
- i_ex_jump_addr  input  32  target of the taken branch/jump.
- i_md_start  input  1  EX instruction starts a mul/div (single-cycle pulse).
- i_md_done  input  1  mul/div unit result ready (single-cycle pulse).
- o_hold_type  output  2  00 none, 01 branch, 10 load/stall.
- o_jump_flag  output  1  redirect PC.
- o_jump_addr  output  32  redirect target.
- o_md_busy  output  1  FSM in MD_BUSY.
- o_md_err  output  1  sticky mul/div timeout flag.
- o_stall_cnt  output  CNT_W  cycles with o_hold_type = 10.
- o_flush_cnt  output  CNT_W  cycles with o_hold_type = 01.

Behaviour:
- **Reset.** While i_reset = 1 at a clock edge:
  - FSM goes to IDLE; wait counter, o_md_err and both perf counters clear to 0.
  - Combinational outputs are forced to o_hold_type = 00, o_jump_flag = 0, o_jump_addr = 0 during reset.
  - Reset mid-MD_BUSY aborts the wait immediately.
- **Timing.** All hold outputs are combinational from inputs and current state (zero latency); the hold controller acts on them in the same cycle.
- **Load-use term.** load_use = i_ex_valid & i_ex_mem_re & i_ex_rd_we & (i_ex_rd_addr != 0) & ((i_id_rs1_re & rs1 == rd) | (i_id_rs2_re & rs2 == rd)). A register index of x0 never hazards.
- **FSM states: IDLE, MD_BUSY.**
- **IDLE**, priority order:
  1. i_ex_valid & i_ex_jump → hold_type 01, jump_flag 1, jump_addr = i_ex_jump_addr.
  2. Else i_ex_valid & i_md_start & !i_md_done → hold_type 10; next state MD_BUSY, wait counter = 1.
  3. Else load_use → hold_type 10.
  4. Else → 00.
- **IDLE, same-cycle done.** i_md_start & i_md_done together means the op completes in one cycle: no hold, stay IDLE.
- **MD_BUSY:**
  - hold_type 10 every cycle until the cycle i_md_done = 1.
  - In the i_md_done cycle: hold_type 00, next state IDLE.
  - i_ex_jump, i_md_start and load_use are ignored while in MD_BUSY.
  - Wait counter increments each cycle.
  - If counter reaches MD_TIMEOUT without done: set o_md_err (sticky until reset), return to IDLE, hold_type 00 that cycle.
- **Bubbles.** When i_ex_valid = 0, the jump, mul/div and load terms are all suppressed. A bubble after a load stall therefore never re-triggers.
- **o_jump_addr** is 0 whenever o_jump_flag = 0.
- **Perf counters.** Update on the clock edge from the current o_hold_type and saturate at all-ones (no wrap).

Test Plan:
1. Reset for 2 cycles with i_ex_jump = 1, then release with all inputs 0 → outputs 00/0/0 during reset; counters 0 afterwards.
2. EX load with rd = 5, we = 1; ID rs2 = 5, re = 1 → hold_type 10 for one cycle, o_stall_cnt = 1. Repeat with rd = 0 → hold_type 00.
3. EX jump = 1, addr = 0x0000_0100, plus a simultaneous load_use → hold_type 01, jump_flag 1, jump_addr 0x100, o_flush_cnt = 1.
4. i_md_start, then i_md_done 4 cycles later → hold_type 10 for exactly 4 cycles, 00 on the done cycle, o_md_busy falls, o_stall_cnt = 4.
5. i_md_start, never done, MD_TIMEOUT = 8 → o_md_err rises at cycle 8, FSM back to IDLE; i_reset = 1 mid-busy in a rerun → IDLE the next cycle, o_md_err cleared.
6. CNT_W = 4, 20 consecutive load stalls → o_stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_req.sv
// -----------------------------------------------------------------------------
// hazard_req
//   EX-stage hold request generator for the hold controller. Flags load-use
//   hazards between ID and EX, taken branches/jumps resolved in EX, and
//   multi-cycle mul/div operations occupying EX. A small FSM tracks the mul/div
//   wait with a timeout watchdog, and two saturating counters record how many
//   cycles were spent stalling and flushing.
//
// Parameters
//   CNT_W       width of o_stall_cnt / o_flush_cnt
//   MD_TIMEOUT  cycles allowed in MD_BUSY before o_md_err is raised
//
// Ports
//   i_clk, i_reset          clock (rising edge), synchronous active-high reset
//   i_id_rs1_addr/_re       ID instruction rs1 index and read enable
//   i_id_rs2_addr/_re       ID instruction rs2 index and read enable
//   i_ex_valid              EX holds a real instruction (0 = bubble)
//   i_ex_mem_re             EX instruction is a load
//   i_ex_rd_addr/_we        EX destination register and write enable
//   i_ex_jump/_jump_addr    EX branch/jump taken and its target
//   i_md_start, i_md_done   mul/div start and result-ready pulses
//   o_hold_type             00 none, 01 branch flush, 10 stall (combinational)
//   o_jump_flag/_jump_addr  PC redirect request and target (combinational)
//   o_md_busy               FSM is waiting on the mul/div unit
//   o_md_err                sticky mul/div timeout flag
//   o_stall_cnt/o_flush_cnt saturating cycle counters for hold types 10 / 01
// -----------------------------------------------------------------------------
module hazard_req #(
   parameter int CNT_W      = 32,
   parameter int MD_TIMEOUT = 64
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [4:0]       i_id_rs1_addr,
   input  logic             i_id_rs1_re,
   input  logic [4:0]       i_id_rs2_addr,
   input  logic             i_id_rs2_re,
   input  logic             i_ex_valid,
   input  logic             i_ex_mem_re,
   input  logic [4:0]       i_ex_rd_addr,
   input  logic             i_ex_rd_we,
   input  logic             i_ex_jump,
   input  logic [31:0]      i_ex_jump_addr,
   input  logic             i_md_start,
   input  logic             i_md_done,
   output logic [1:0]       o_hold_type,
   output logic             o_jump_flag,
   output logic [31:0]      o_jump_addr,
   output logic             o_md_busy,
   output logic             o_md_err,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   localparam int WC_W = $clog2(MD_TIMEOUT + 1);

   localparam logic [1:0] HOLD_NONE   = 2'b00;
   localparam logic [1:0] HOLD_BRANCH = 2'b01;
   localparam logic [1:0] HOLD_STALL  = 2'b10;

   typedef enum logic {IDLE, MD_BUSY} state_t;

   state_t          state;
   logic [WC_W-1:0] wait_cnt;
   logic            load_use;
   logic            md_go;       // IDLE -> MD_BUSY this cycle
   logic            md_timeout;  // watchdog expires this cycle

   // x0 is hard-wired zero, so it can never carry a real dependency.
   assign load_use = i_ex_valid & i_ex_mem_re & i_ex_rd_we & (i_ex_rd_addr != 5'd0) &
                     ((i_id_rs1_re & (i_id_rs1_addr == i_ex_rd_addr)) |
                      (i_id_rs2_re & (i_id_rs2_addr == i_ex_rd_addr)));

   // NOTE: every output of this block gets a default first so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      o_hold_type = HOLD_NONE;
      o_jump_flag = 1'b0;
      o_jump_addr = 32'd0;
      md_go       = 1'b0;
      md_timeout  = 1'b0;
      if (!i_reset) begin
         if (state == IDLE) begin
            if (i_ex_valid & i_ex_jump) begin
               o_hold_type = HOLD_BRANCH;
               o_jump_flag = 1'b1;
               o_jump_addr = i_ex_jump_addr;
            end else if (i_ex_valid & i_md_start & !i_md_done) begin
               // A start with done in the same cycle is a one-cycle op: no hold.
               o_hold_type = HOLD_STALL;
               md_go       = 1'b1;
            end else if (load_use) begin
               o_hold_type = HOLD_STALL;
            end
         end else begin
            // Jumps, new starts and load-use are ignored while waiting.
            if (i_md_done) begin
               o_hold_type = HOLD_NONE;
            end else if (wait_cnt == WC_W'(MD_TIMEOUT)) begin
               md_timeout = 1'b1;
            end else begin
               o_hold_type = HOLD_STALL;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         o_md_err <= 1'b0;
      end else if (state == IDLE) begin
         if (md_go) begin
            state    <= MD_BUSY;
            wait_cnt <= WC_W'(1);
         end
      end else begin
         if (i_md_done) begin
            state <= IDLE;
         end else if (md_timeout) begin
            state    <= IDLE;
            o_md_err <= 1'b1;
         end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
         end
      end
   end

   assign o_md_busy = (state == MD_BUSY);

   // Counters stop at all-ones rather than wrapping to a misleading small value.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if ((o_hold_type == HOLD_STALL) && (o_stall_cnt != '1))
            o_stall_cnt <= o_stall_cnt + CNT_W'(1);
         if ((o_hold_type == HOLD_BRANCH) && (o_flush_cnt != '1))
            o_flush_cnt <= o_flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_req.sv
// -----------------------------------------------------------------------------
// tb_hazard_req
//   Directed bench for hazard_req. Two instances share all inputs: a 32-bit
//   counter build and a 4-bit counter build, both with MD_TIMEOUT = 8.
//   Inputs change 1 time unit after a rising edge; outputs are sampled before
//   the next rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_req;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        rs1_re, rs2_re, ex_valid, mem_re, rd_we, jump, md_start, md_done;
   logic [31:0] jump_addr;

   logic [1:0]  hold_type, hold_type_s;
   logic        jump_flag, jump_flag_s, md_busy, md_busy_s, md_err, md_err_s;
   logic [31:0] jaddr, jaddr_s, stall_cnt, flush_cnt;
   logic [3:0]  stall_cnt_s, flush_cnt_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_req #(.CNT_W(32), .MD_TIMEOUT(8)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_id_rs1_addr(rs1_addr), .i_id_rs1_re(rs1_re),
      .i_id_rs2_addr(rs2_addr), .i_id_rs2_re(rs2_re),
      .i_ex_valid(ex_valid), .i_ex_mem_re(mem_re),
      .i_ex_rd_addr(rd_addr), .i_ex_rd_we(rd_we),
      .i_ex_jump(jump), .i_ex_jump_addr(jump_addr),
      .i_md_start(md_start), .i_md_done(md_done),
      .o_hold_type(hold_type), .o_jump_flag(jump_flag), .o_jump_addr(jaddr),
      .o_md_busy(md_busy), .o_md_err(md_err),
      .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
   );

   hazard_req #(.CNT_W(4), .MD_TIMEOUT(8)) dut_s (
      .i_clk(clk), .i_reset(rst),
      .i_id_rs1_addr(rs1_addr), .i_id_rs1_re(rs1_re),
      .i_id_rs2_addr(rs2_addr), .i_id_rs2_re(rs2_re),
      .i_ex_valid(ex_valid), .i_ex_mem_re(mem_re),
      .i_ex_rd_addr(rd_addr), .i_ex_rd_we(rd_we),
      .i_ex_jump(jump), .i_ex_jump_addr(jump_addr),
      .i_md_start(md_start), .i_md_done(md_done),
      .o_hold_type(hold_type_s), .o_jump_flag(jump_flag_s), .o_jump_addr(jaddr_s),
      .o_md_busy(md_busy_s), .o_md_err(md_err_s),
      .o_stall_cnt(stall_cnt_s), .o_flush_cnt(flush_cnt_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rs1_addr = 5'd0; rs1_re = 1'b0; rs2_addr = 5'd0; rs2_re = 1'b0;
      ex_valid = 1'b0; mem_re = 1'b0; rd_addr = 5'd0; rd_we = 1'b0;
      jump = 1'b0; jump_addr = 32'd0; md_start = 1'b0; md_done = 1'b0;
   endtask

   // EX load writing rd, ID instruction reading rs2.
   task automatic set_load_rs2(input logic [4:0] rd, input logic [4:0] rs2);
      ex_valid = 1'b1; mem_re = 1'b1; rd_we = 1'b1; rd_addr = rd;
      rs2_re = 1'b1; rs2_addr = rs2;
   endtask

   initial begin
      // ---- 1. reset with a valid jump asserted: hold outputs forced low ----
      clear_inputs();
      rst = 1'b1; ex_valid = 1'b1; jump = 1'b1; jump_addr = 32'hDEAD_BEEF;
      #1;
      check("rst_hold", 32'(hold_type), 32'd0);
      check("rst_jflag", 32'(jump_flag), 32'd0);
      check("rst_jaddr", jaddr, 32'd0);
      tick();
      tick();
      check("rst_hold_2", 32'(hold_type), 32'd0);
      rst = 1'b0;
      clear_inputs();
      #1;
      check("idle_hold", 32'(hold_type), 32'd0);
      check("rst_stall", stall_cnt, 32'd0);
      check("rst_flush", flush_cnt, 32'd0);
      check("rst_busy", 32'(md_busy), 32'd0);
      check("rst_err", 32'(md_err), 32'd0);

      // ---- 2. load-use on rs2 ----
      set_load_rs2(5'd5, 5'd5);
      #1 check("lu_rs2_hold", 32'(hold_type), 32'd2);
      tick();
      clear_inputs();
      check("lu_stall_1", stall_cnt, 32'd1);
      set_load_rs2(5'd0, 5'd0);                 // x0 never hazards
      #1 check("lu_x0_hold", 32'(hold_type), 32'd0);
      tick();
      clear_inputs();
      set_load_rs2(5'd5, 5'd5); ex_valid = 1'b0; // bubble suppresses the term
      #1 check("lu_bubble_hold", 32'(hold_type), 32'd0);
      tick();
      clear_inputs();
      ex_valid = 1'b1; mem_re = 1'b1; rd_we = 1'b1; rd_addr = 5'd7;
      rs1_addr = 5'd7; rs1_re = 1'b1;
      #1 check("lu_rs1_hold", 32'(hold_type), 32'd2);
      tick();
      rs1_re = 1'b0;                             // matching index but not read
      #1 check("lu_rs1_nore_hold", 32'(hold_type), 32'd0);
      check("lu_stall_2", stall_cnt, 32'd2);
      tick();
      clear_inputs();

      // ---- 3. jump beats a simultaneous load-use ----
      set_load_rs2(5'd5, 5'd5);
      jump = 1'b1; jump_addr = 32'h0000_0100;
      #1;
      check("jmp_hold", 32'(hold_type), 32'd1);
      check("jmp_flag", 32'(jump_flag), 32'd1);
      check("jmp_addr", jaddr, 32'h0000_0100);
      tick();
      clear_inputs();
      check("jmp_flush_1", flush_cnt, 32'd1);
      check("jmp_stall_2", stall_cnt, 32'd2);
      jump = 1'b1; jump_addr = 32'h0000_0200;    // jump on a bubble: ignored
      #1;
      check("jmp_bubble_flag", 32'(jump_flag), 32'd0);
      check("jmp_bubble_addr", jaddr, 32'd0);
      tick();
      clear_inputs();

      // ---- 4. mul/div done 4 cycles after start ----
      ex_valid = 1'b1; md_start = 1'b1;
      #1 check("md_start_hold", 32'(hold_type), 32'd2);
      check("md_start_busy", 32'(md_busy), 32'd0);
      tick();
      md_start = 1'b0;
      check("md_busy_rise", 32'(md_busy), 32'd1);
      jump = 1'b1; jump_addr = 32'h0000_0300;    // ignored while busy
      set_load_rs2(5'd9, 5'd9);
      for (int i = 1; i <= 3; i++) begin
         #1;
         check($sformatf("md_wait_hold_%0d", i), 32'(hold_type), 32'd2);
         check($sformatf("md_wait_jflag_%0d", i), 32'(jump_flag), 32'd0);
         tick();
      end
      clear_inputs();
      md_done = 1'b1;
      #1 check("md_done_hold", 32'(hold_type), 32'd0);
      tick();
      md_done = 1'b0;
      check("md_busy_fall", 32'(md_busy), 32'd0);
      check("md_stall_6", stall_cnt, 32'd6);
      ex_valid = 1'b1; md_start = 1'b1; md_done = 1'b1; // single-cycle op
      #1 check("md_same_hold", 32'(hold_type), 32'd0);
      tick();
      clear_inputs();
      check("md_same_busy", 32'(md_busy), 32'd0);
      check("md_same_stall", stall_cnt, 32'd6);

      // ---- 5. timeout watchdog (MD_TIMEOUT = 8) ----
      ex_valid = 1'b1; md_start = 1'b1;
      tick();
      clear_inputs();
      for (int i = 1; i <= 7; i++) begin
         #1 check($sformatf("to_hold_%0d", i), 32'(hold_type), 32'd2);
         tick();
      end
      check("to_err_pre", 32'(md_err), 32'd0);
      check("to_busy_pre", 32'(md_busy), 32'd1);
      #1 check("to_hold_8", 32'(hold_type), 32'd0);
      tick();
      check("to_err", 32'(md_err), 32'd1);
      check("to_busy", 32'(md_busy), 32'd0);
      check("to_stall_14", stall_cnt, 32'd14);
      tick();
      check("to_err_sticky", 32'(md_err), 32'd1);
      ex_valid = 1'b1; md_start = 1'b1;          // rerun, reset mid-busy
      tick();
      clear_inputs();
      tick();
      check("rr_busy", 32'(md_busy), 32'd1);
      rst = 1'b1;
      #1 check("rr_rst_hold", 32'(hold_type), 32'd0);
      tick();
      rst = 1'b0;
      check("rr_busy_after", 32'(md_busy), 32'd0);
      check("rr_err_after", 32'(md_err), 32'd0);
      check("rr_stall_after", stall_cnt, 32'd0);

      // ---- 6. 20 consecutive load stalls: 4-bit counter saturates ----
      set_load_rs2(5'd3, 5'd3);
      for (int i = 0; i < 20; i++) tick();
      clear_inputs();
      check("sat_stall_s", 32'(stall_cnt_s), 32'd15);
      check("sat_stall_w", stall_cnt, 32'd20);
      check("sat_flush_s", 32'(flush_cnt_s), 32'd0);
      tick();
      check("sat_stall_s_hold", 32'(stall_cnt_s), 32'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
